// File: rtl/result_axis_packer_pkg.sv
// result_axis_packer_pkg: shared systolic-array stream types and sizes
package result_axis_packer_pkg;
    localparam int SA_ROWS    = 4;
    localparam int SA_COLS    = 4;
    localparam int SA_DATA_W  = 32;
    localparam int SA_PKT_LEN = SA_ROWS * SA_COLS;
    localparam int SA_KEEP_W  = SA_DATA_W / 8;
endpackage

// File: rtl/result_axis_packer_if.sv
// result_axis_packer_if: upstream word strobe plus AXI4-Stream output bundle
interface result_axis_packer_if import result_axis_packer_pkg::*; #(
    parameter int DATA_W = SA_DATA_W
) ();
    logic                  i_valid;
    logic [DATA_W-1:0]     i_data;
    logic                  o_tvalid;
    logic                  i_tready;
    logic [DATA_W-1:0]     o_tdata;
    logic                  o_tlast;
    logic [DATA_W/8-1:0]   o_tkeep;
    modport master (input i_valid, i_data, i_tready, output o_tvalid, o_tdata, o_tlast, o_tkeep);
    modport slave  (output i_valid, i_data, i_tready, input o_tvalid, o_tdata, o_tlast, o_tkeep);
endinterface

// File: rtl/result_axis_packer_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with wrap-bit pointers
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr, r_rd_ptr;
    logic              w_wr, w_rd;
    assign o_empty   = r_wr_ptr == r_rd_ptr;
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    // a write into a full FIFO is legal only when the same cycle frees a slot
    assign w_wr = i_wr_en && (!o_full || i_rd_en);
    assign w_rd = i_rd_en && !o_empty;
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
endmodule

// File: rtl/result_axis_packer.sv
// result_axis_packer: buffers unthrottled result bursts and re-emits them as TLAST-framed AXI4-Stream packets
module result_axis_packer import result_axis_packer_pkg::*; #(
    parameter int DATA_W  = SA_DATA_W,
    parameter int DEPTH   = 32,
    parameter int PKT_LEN = SA_PKT_LEN
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    result_axis_packer_if.master axis,
    output logic                 o_overflow,
    output logic [15:0]          o_pkt_count,
    output logic                 o_busy
);
    localparam int BW = $clog2(PKT_LEN);
    logic              r_tvalid, r_overflow;
    logic [DATA_W-1:0] r_tdata;
    logic [BW-1:0]     r_beat;
    logic [15:0]       r_pkt_count;
    logic              w_hs, w_slot, w_pop, w_bypass, w_push, w_drop, w_last, w_full, w_empty;
    logic [DATA_W-1:0] w_head;
    assign w_hs     = r_tvalid && axis.i_tready;
    assign w_slot   = !r_tvalid || w_hs;
    assign w_pop    = w_slot && !w_empty;
    // an empty FIFO with a free output slot lets the word skip the FIFO entirely
    assign w_bypass = axis.i_valid && w_empty && w_slot;
    assign w_push   = axis.i_valid && !w_bypass && (!w_full || w_pop);
    assign w_drop   = axis.i_valid && !w_bypass && w_full && !w_pop;
    assign w_last   = r_tvalid && (r_beat == BW'(PKT_LEN - 1));
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_push),
        .i_wr_data (axis.i_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_beat      <= '0;
            r_pkt_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_pop || w_bypass) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_pop ? w_head : axis.i_data;
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
            end
            if (w_hs) begin
                r_beat      <= w_last ? '0 : r_beat + 1'b1;
                r_pkt_count <= r_pkt_count + 16'(w_last);
            end
            r_overflow <= r_overflow | w_drop;
        end
    end
    assign axis.o_tvalid = r_tvalid;
    assign axis.o_tdata  = r_tdata;
    assign axis.o_tlast  = w_last;
    assign axis.o_tkeep  = '1;
    assign o_overflow    = r_overflow;
    assign o_pkt_count   = r_pkt_count;
    assign o_busy        = !w_empty || r_tvalid || (r_beat != '0);
endmodule

// File: tb/tb_result_axis_packer.sv
// tb_result_axis_packer: scenario table plus random soak checked against a queue-based packet model
module tb_result_axis_packer;
    localparam int DEPTH = 32;
    localparam int PKT   = 16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ovf, busy;
    logic [15:0] pkt;
    int          checks = 0, failures = 0;
    int          dut_beats, dut_lasts;
    logic [31:0] q[$];
    int          m_beat;
    int          m_pkts;
    bit          m_ovf;
    typedef struct {
        int n; int base; int mode; int hold;
        int exp_beats; int exp_lasts; int exp_ovf; int exp_pkts; int exp_busy;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    result_axis_packer_if #(.DATA_W(32)) bus ();
    result_axis_packer #(.DATA_W(32), .DEPTH(DEPTH), .PKT_LEN(PKT)) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .axis        (bus.master),
        .o_overflow  (ovf),
        .o_pkt_count (pkt),
        .o_busy      (busy)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // one clock: drive at the falling edge, compare against the model, then advance the model across the next rising edge
    task automatic cycle(input bit v, input logic [31:0] d, input bit r, input bit rs = 1'b1);
        bit exp_last;
        @(negedge clk);
        rst_n = rs;
        bus.i_valid = v;
        bus.i_data = d;
        bus.i_tready = r;
        #1;
        exp_last = (q.size() > 0) && (m_beat == PKT - 1);
        chk("tvalid", 32'(bus.o_tvalid), 32'(q.size() > 0));
        chk("tlast", 32'(bus.o_tlast), 32'(exp_last));
        if (q.size() > 0) chk("tdata", bus.o_tdata, q[0]);
        chk("tkeep", 32'(bus.o_tkeep), 32'hF);
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("pkt_count", 32'(pkt), 32'(m_pkts));
        chk("busy", 32'(busy), 32'((q.size() > 0) || (m_beat != 0)));
        if (bus.o_tvalid && r) begin
            dut_beats++;
            if (bus.o_tlast) dut_lasts++;
        end
        if (!rs) begin
            q.delete();
            m_beat = 0;
            m_pkts = 0;
            m_ovf = 1'b0;
        end else begin
            if (q.size() > 0 && r) begin
                void'(q.pop_front());
                m_beat = (m_beat + 1) % PKT;
                if (m_beat == 0) m_pkts = (m_pkts + 1) % 65536;
            end
            if (v) begin
                if (q.size() < DEPTH + 1) q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        dut_beats = 0;
        dut_lasts = 0;
    endtask

    task automatic drain(input int mode);
        for (int i = 0; i < 400 && q.size() > 0; i++)
            cycle(1'b0, 32'h0, mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1);
        chk("drain_done", 32'(q.size()), 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{n:16, base:32'h1,   mode:0, hold:0, exp_beats:16, exp_lasts:1, exp_ovf:0, exp_pkts:1, exp_busy:0};
        tbl[1] = '{n:16, base:32'h200, mode:1, hold:5, exp_beats:16, exp_lasts:1, exp_ovf:0, exp_pkts:1, exp_busy:0};
        tbl[2] = '{n:34, base:32'h0,   mode:1, hold:0, exp_beats:33, exp_lasts:2, exp_ovf:1, exp_pkts:2, exp_busy:1};
        tbl[3] = '{n:32, base:32'h100, mode:2, hold:0, exp_beats:32, exp_lasts:2, exp_ovf:0, exp_pkts:2, exp_busy:0};
        tbl[4] = '{n:5,  base:32'h400, mode:0, hold:0, exp_beats:5,  exp_lasts:0, exp_ovf:0, exp_pkts:0, exp_busy:1};
        q.delete();
        m_beat = 0;
        m_pkts = 0;
        m_ovf = 1'b0;
        dut_beats = 0;
        dut_lasts = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data = '0;
        bus.i_tready = 1'b0;
        repeat (3) @(posedge clk);
        cycle(1'b0, 32'h0, 1'b0);
        chk("reset_tvalid", 32'(bus.o_tvalid), 32'h0);
        chk("reset_pkt", 32'(pkt), 32'h0);
        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int i = 0; i < tbl[t].n; i++)
                cycle(1'b1, 32'(tbl[t].base + i),
                      tbl[t].mode == 0 ? 1'b1 : tbl[t].mode == 1 ? 1'b0 : 1'($urandom_range(0, 1)));
            for (int i = 0; i < tbl[t].hold; i++) cycle(1'b0, 32'h0, 1'b0);
            drain(tbl[t].mode);
            chk("vec_beats", 32'(dut_beats), 32'(tbl[t].exp_beats));
            chk("vec_lasts", 32'(dut_lasts), 32'(tbl[t].exp_lasts));
            chk("vec_ovf", 32'(ovf), 32'(tbl[t].exp_ovf));
            chk("vec_pkts", 32'(pkt), 32'(tbl[t].exp_pkts));
            chk("vec_busy", 32'(busy), 32'(tbl[t].exp_busy));
        end
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 32'(32'h500 + i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'(32'h600 + i), 1'b1);
        chk("fullrw_ovf", 32'(ovf), 32'h0);
        drain(0);
        chk("fullrw_beats", 32'(dut_beats), 32'd43);
        chk("fullrw_pkts", 32'(pkt), 32'd2);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'(32'h700 + i), 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("midrst_tvalid", 32'(bus.o_tvalid), 32'h0);
        chk("midrst_pkt", 32'(pkt), 32'h0);
        dut_beats = 0;
        dut_lasts = 0;
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(32'h800 + i), 1'b1);
        drain(0);
        chk("midrst_lasts", 32'(dut_lasts), 32'd1);
        chk("midrst_pkts", 32'(pkt), 32'd1);
        do_reset();
        for (int i = 0; i < 500; i++)
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0));
        drain(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
